// File: rtl/cache_line_refill_pkg.sv
// Shared types and geometry for the cache line refill engine.
package cache_line_refill_pkg;

    localparam int ADDR_WIDTH  = 8;                        // data-RAM word address width
    localparam int LINE_WLOG2  = 2;                        // log2(words per line)
    localparam int LINE_WORDS  = 1 << LINE_WLOG2;
    localparam int TAG_WIDTH   = 30 - ADDR_WIDTH;          // tag = byte addr[31:ADDR_WIDTH+2]
    localparam int INDEX_WIDTH = ADDR_WIDTH - LINE_WLOG2;
    localparam int LINE_AWIDTH = 30 - LINE_WLOG2;          // byte addr[31:LINE_WLOG2+2]

    typedef enum logic [2:0] {
        IDLE,
        WB_RD,
        WB_LAT,
        WB_REQ,
        FILL_REQ,
        FILL_WR,
        DONE
    } refillState_t;

endpackage

// File: rtl/cache_line_refill_if.sv
// Miss request, data-RAM replacement port and memory bus of the refill engine.
// master = refill engine side, slave = cache/RAM/memory side.
interface cache_line_refill_if;
    import cache_line_refill_pkg::*;

    logic                  start;
    logic [31:0]           missAddress;
    logic [1:0]            victimCh;
    logic                  victimDirty;
    logic [TAG_WIDTH-1:0]  victimTag;
    logic                  busy;
    logic                  done;
    logic                  sel;

    logic [ADDR_WIDTH-1:0] ri_readAddress;
    logic [1:0]            ri_rwChannel;
    logic [31:0]           ri_readData;
    logic [ADDR_WIDTH-1:0] ri_writeAddress;
    logic [3:0]            ri_writeByteEnable;
    logic                  ri_writeEnable;
    logic [31:0]           ri_writeData;

    logic                  mem_req;
    logic                  mem_we;
    logic [31:0]           mem_address;
    logic [31:0]           mem_writeData;
    logic                  mem_ack;
    logic [31:0]           mem_readData;

    modport master (
        input  start, missAddress, victimCh, victimDirty, victimTag,
        output busy, done, sel,
        output ri_readAddress, ri_rwChannel, ri_writeAddress, ri_writeByteEnable,
        output ri_writeEnable, ri_writeData,
        input  ri_readData,
        output mem_req, mem_we, mem_address, mem_writeData,
        input  mem_ack, mem_readData
    );

    modport slave (
        output start, missAddress, victimCh, victimDirty, victimTag,
        input  busy, done, sel,
        input  ri_readAddress, ri_rwChannel, ri_writeAddress, ri_writeByteEnable,
        input  ri_writeEnable, ri_writeData,
        output ri_readData,
        input  mem_req, mem_we, mem_address, mem_writeData,
        output mem_ack, mem_readData
    );

endinterface

// File: rtl/cache_line_refill.sv
// Miss-service engine: optional word-by-word writeback of a dirty victim line,
// then linear refill of the line from memory into the data-RAM.
module cache_line_refill
    import cache_line_refill_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    cache_line_refill_if.master  bus
);

    refillState_t            state, nextState;
    logic [LINE_AWIDTH-1:0]  lineAddr;    // latched missAddress[31:LINE_WLOG2+2]
    logic [1:0]              chLatch;
    logic [TAG_WIDTH-1:0]    tagLatch;
    logic [LINE_WLOG2-1:0]   cnt;
    logic [31:0]             wbData;
    logic [31:0]             fillData;

    logic [INDEX_WIDTH-1:0]  lineIndex;
    logic [ADDR_WIDTH-1:0]   ramWord;
    logic                    lastWord;

    assign lineIndex = lineAddr[INDEX_WIDTH-1:0];
    assign ramWord   = {lineIndex, cnt};
    assign lastWord  = &cnt;

    // State register; reset aborts any operation straight back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Request latches, word counter and the two data holding registers.
    // victimDirty is only consulted at accept, so it is not kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            lineAddr <= '0;
            chLatch  <= '0;
            tagLatch <= '0;
            cnt      <= '0;
            wbData   <= '0;
            fillData <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    lineAddr <= bus.missAddress[31:LINE_WLOG2+2];
                    chLatch  <= bus.victimCh;
                    tagLatch <= bus.victimTag;
                    cnt      <= '0;
                end
                WB_LAT:   wbData <= bus.ri_readData;
                WB_REQ:   if (bus.mem_ack) cnt <= cnt + 1'b1;   // wraps to 0 after last word
                FILL_REQ: if (bus.mem_ack) fillData <= bus.mem_readData;
                FILL_WR:  cnt <= cnt + 1'b1;
                default:  ;
            endcase
        end
    end

    // Next-state and control strobes; all strobes decode directly from state.
    always_comb begin
        nextState          = state;
        bus.busy           = 1'b1;
        bus.sel            = 1'b1;
        bus.done           = 1'b0;
        bus.mem_req        = 1'b0;
        bus.mem_we         = 1'b0;
        bus.ri_writeEnable = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                bus.sel  = 1'b0;
                if (bus.start) nextState = bus.victimDirty ? WB_RD : FILL_REQ;
            end
            WB_RD:  nextState = WB_LAT;
            WB_LAT: nextState = WB_REQ;
            WB_REQ: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                if (bus.mem_ack) nextState = lastWord ? FILL_REQ : WB_RD;
            end
            FILL_REQ: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) nextState = FILL_WR;
            end
            FILL_WR: begin
                bus.ri_writeEnable = 1'b1;
                nextState = lastWord ? DONE : FILL_REQ;
            end
            DONE: begin
                bus.done  = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign bus.ri_readAddress     = ramWord;
    assign bus.ri_writeAddress    = ramWord;
    assign bus.ri_rwChannel       = chLatch;
    assign bus.ri_writeByteEnable = 4'hF;
    assign bus.ri_writeData       = fillData;
    assign bus.mem_writeData      = wbData;
    // Writeback targets the victim's home address, refill the missing line.
    assign bus.mem_address = (state == WB_REQ) ? {tagLatch, lineIndex, cnt, 2'b00}
                                               : {lineAddr, cnt, 2'b00};

endmodule

// File: tb/tb_cache_line_refill.sv
// Directed bench for cache_line_refill: RAM and memory models, a per-cycle
// compare against expected transaction queues, and literal pins per scenario.
module tb_cache_line_refill;
    import cache_line_refill_pkg::*;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } memTxn_t;
    typedef struct { logic [7:0] addr; logic [1:0] ch; logic [31:0] data; } ramTxn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_line_refill_if bus();
    cache_line_refill dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] ram [4][256];
    int          ackDelay;
    int          waitCnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int startCyc, expLat, lastLat;
    int doneCount = 0;
    int fillAcks  = 0;
    logic [1:0] expCh;

    memTxn_t memQ[$];
    ramTxn_t ramQ[$];
    memTxn_t memLog[$];
    ramTxn_t ramLog[$];

    logic        prevReq, prevAck, prevWe;
    logic [31:0] prevAddr, prevWdata;

    // Synchronous-read data-RAM model.
    always @(posedge clk) bus.ri_readData <= ram[bus.ri_rwChannel][bus.ri_readAddress];

    // Memory slave: ack after ackDelay extra cycles; read data 0xA0 + word offset.
    always @(posedge clk) begin
        if (rst) begin
            bus.mem_ack      <= 1'b0;
            bus.mem_readData <= '0;
            waitCnt          <= 0;
        end else if (bus.mem_ack) begin
            bus.mem_ack <= 1'b0;
        end else if (bus.mem_req) begin
            if (waitCnt >= ackDelay) begin
                bus.mem_ack      <= 1'b1;
                bus.mem_readData <= 32'hA0 + {30'd0, bus.mem_address[3:2]};
                waitCnt          <= 0;
            end else begin
                waitCnt <= waitCnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the expected transaction queues.
    task automatic compareCycle();
        memTxn_t m;
        ramTxn_t r;
        check("sel_eq_busy", {31'd0, bus.sel}, {31'd0, bus.busy});
        check("byte_enable", {28'd0, bus.ri_writeByteEnable}, 32'hF);
        if (bus.busy) check("rw_channel", {30'd0, bus.ri_rwChannel}, {30'd0, expCh});
        if (bus.mem_req && prevReq && !prevAck) begin
            check("req_addr_stable", bus.mem_address, prevAddr);
            check("req_we_stable", {31'd0, bus.mem_we}, {31'd0, prevWe});
            if (bus.mem_we) check("req_wdata_stable", bus.mem_writeData, prevWdata);
        end
        if (bus.mem_req && bus.mem_ack) begin
            memLog.push_back('{bus.mem_we, bus.mem_address, bus.mem_writeData});
            if (!bus.mem_we) fillAcks++;
            if (memQ.size() == 0) check("mem_txn_unexpected", 32'd1, 32'd0);
            else begin
                m = memQ.pop_front();
                check("mem_we", {31'd0, bus.mem_we}, {31'd0, m.we});
                check("mem_address", bus.mem_address, m.addr);
                if (m.we) check("mem_writeData", bus.mem_writeData, m.data);
            end
        end
        if (bus.ri_writeEnable) begin
            ramLog.push_back('{bus.ri_writeAddress, bus.ri_rwChannel, bus.ri_writeData});
            if (ramQ.size() == 0) check("ram_write_unexpected", 32'd1, 32'd0);
            else begin
                r = ramQ.pop_front();
                check("ram_waddr", {24'd0, bus.ri_writeAddress}, {24'd0, r.addr});
                check("ram_wch", {30'd0, bus.ri_rwChannel}, {30'd0, r.ch});
                check("ram_wdata", bus.ri_writeData, r.data);
            end
        end
        if (bus.done) begin
            doneCount++;
            lastLat = cyc + 1 - startCyc;
            check("done_latency", lastLat, expLat);
            check("done_memq_empty", memQ.size(), 0);
            check("done_ramq_empty", ramQ.size(), 0);
        end
        prevReq   = bus.mem_req;
        prevAck   = bus.mem_ack;
        prevWe    = bus.mem_we;
        prevAddr  = bus.mem_address;
        prevWdata = bus.mem_writeData;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        compareCycle();
    endtask

    // Model: what a miss must do, in transaction order, and how long it takes.
    task automatic planMiss(input logic [31:0] addr, input logic [1:0] ch, input logic dirty,
                            input logic [21:0] tag, input int delay);
        int idx;
        idx = (addr >> 4) & 32'h3F;
        if (dirty)
            for (int w = 0; w < 4; w++)
                memQ.push_back('{1'b1, (32'(tag) << 10) | 32'(idx << 4) | 32'(w << 2),
                                 ram[ch][idx*4 + w]});
        for (int w = 0; w < 4; w++) begin
            memQ.push_back('{1'b0, (addr & 32'hFFFF_FFF0) | 32'(w << 2), 32'd0});
            ramQ.push_back('{8'(idx*4 + w), ch, 32'hA0 + 32'(w)});
        end
        expLat = (dirty ? 4*(4 + delay) : 0) + 4*(3 + delay) + 1;
    endtask

    task automatic runMiss(input logic [31:0] addr, input logic [1:0] ch, input logic dirty,
                           input logic [21:0] tag, input int delay, input logic injectStart);
        int  d0;
        logic injected;
        injected = 1'b0;
        memLog.delete();
        ramLog.delete();
        ackDelay = delay;
        expCh    = ch;
        planMiss(addr, ch, dirty, tag, delay);
        bus.start       = 1'b1;
        bus.missAddress = addr;
        bus.victimCh    = ch;
        bus.victimDirty = dirty;
        bus.victimTag   = tag;
        startCyc        = cyc + 1;
        d0              = doneCount;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 1000 && doneCount == d0; i++) begin
            tick();
            if (injectStart && !injected && bus.mem_req && !bus.mem_we) begin
                bus.start       = 1'b1;
                bus.missAddress = 32'h0000_4560;
                bus.victimCh    = 2'd0;
                bus.victimDirty = 1'b1;
                injected        = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        check("done_seen", doneCount, d0 + 1);
        tick();
        check("idle_after_done", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int d0;
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 256; a++) ram[c][a] = 32'd0;
        for (int w = 0; w < 4; w++) ram[1][8'h8C + w] = 32'h11 + 32'(w);
        ackDelay = 0;
        expCh = 2'd0;
        bus.start = 1'b0; bus.missAddress = '0; bus.victimCh = '0;
        bus.victimDirty = 1'b0; bus.victimTag = '0;
        rst = 1'b1;
        tick(); tick();
        // Reset state
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sel", {31'd0, bus.sel}, 32'd0);
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_ri_we", {31'd0, bus.ri_writeEnable}, 32'd0);
        check("rst_mem_addr", bus.mem_address, 32'd0);
        check("rst_mem_wdata", bus.mem_writeData, 32'd0);
        check("rst_ri_waddr", {24'd0, bus.ri_writeAddress}, 32'd0);
        check("rst_ri_wdata", bus.ri_writeData, 32'd0);
        rst = 1'b0;
        tick();

        // 1: clean miss
        runMiss(32'h0000_1230, 2'd2, 1'b0, 22'd0, 0, 1'b0);
        check("t1_latency", lastLat, 13);
        check("t1_mem0", memLog.size() > 0 ? memLog[0].addr : 32'hX, 32'h1230);
        check("t1_mem3", memLog.size() > 3 ? memLog[3].addr : 32'hX, 32'h123C);
        check("t1_mem3_we", memLog.size() > 3 ? {31'd0, memLog[3].we} : 32'hX, 32'd0);
        check("t1_ram0_addr", ramLog.size() > 0 ? {24'd0, ramLog[0].addr} : 32'hX, 32'h8C);
        check("t1_ram3", ramLog.size() > 3 ? {ramLog[3].addr, ramLog[3].data[23:0]} : 32'hX,
              32'h8F00_00A3);

        // 2: dirty miss
        runMiss(32'h0000_1230, 2'd1, 1'b1, 22'h155, 0, 1'b0);
        check("t2_latency", lastLat, 29);
        check("t2_wb0_addr", memLog.size() > 0 ? memLog[0].addr : 32'hX, 32'h0005_5630);
        check("t2_wb0_data", memLog.size() > 0 ? memLog[0].data : 32'hX, 32'h11);
        check("t2_wb3", memLog.size() > 3 ? memLog[3].addr ^ memLog[3].data : 32'hX,
              32'h0005_563C ^ 32'h14);
        check("t2_first_read", memLog.size() > 4 ? {memLog[4].addr[30:0], memLog[4].we} : 32'hX,
              32'h2460);

        // 3: slow memory, dirty miss
        runMiss(32'h0000_1230, 2'd1, 1'b1, 22'h155, 5, 1'b0);
        check("t3_latency", lastLat, 69);

        // 4: start during FILL_REQ is ignored
        d0 = doneCount;
        runMiss(32'h0000_2340, 2'd0, 1'b0, 22'd0, 0, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        check("t4_one_done", doneCount, d0 + 1);
        check("t4_busy_idle", {31'd0, bus.busy}, 32'd0);

        // 5: reset during second FILL_REQ
        ackDelay = 0;
        expCh = 2'd2;
        fillAcks = 0;
        planMiss(32'h0000_1230, 2'd2, 1'b0, 22'd0, 0);
        bus.start = 1'b1; bus.missAddress = 32'h0000_1230; bus.victimCh = 2'd2;
        bus.victimDirty = 1'b0;
        startCyc = cyc + 1;
        d0 = doneCount;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 200 && !(fillAcks == 1 && bus.mem_req && !bus.mem_ack); i++) tick();
        check("t5_reached_fill2", fillAcks, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_sel", {31'd0, bus.sel}, 32'd0);
        check("t5_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("t5_busy", {31'd0, bus.busy}, 32'd0);
        memQ.delete();
        ramQ.delete();
        for (int i = 0; i < 12; i++) tick();
        check("t5_no_done", doneCount, d0);

        // 6: top index, channel 3
        runMiss(32'hFFFF_FFF0, 2'd3, 1'b0, 22'd0, 0, 1'b0);
        check("t6_ram0", ramLog.size() > 0 ? {24'd0, ramLog[0].addr} : 32'hX, 32'hFC);
        check("t6_ram3", ramLog.size() > 3 ? {24'd0, ramLog[3].addr} : 32'hX, 32'hFF);
        check("t6_mem3", memLog.size() > 3 ? memLog[3].addr : 32'hX, 32'hFFFF_FFFC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
